// File: rtl/cursor_window_pkg.sv
// Shared encodings and default bounds for the cursor window overlay.
// All positional arithmetic is 14 bits wide so sums and differences never wrap.
package cursor_window_pkg;

  localparam int CW = 14;

  typedef enum logic [1:0] {
    MODE_PASS_IN  = 2'd0,
    MODE_PASS_OUT = 2'd1,
    MODE_INVERT   = 2'd2
  } mode_e;

  // One-hot mode_sel codes: {invert, pass-outside, pass-inside}
  localparam logic [2:0] MSEL_PASS_IN  = 3'b001;
  localparam logic [2:0] MSEL_PASS_OUT = 3'b010;
  localparam logic [2:0] MSEL_INVERT   = 3'b100;

  // One-hot size_sel codes: {SIZE3, SIZE2, SIZE1, off}
  localparam logic [3:0] SSEL_OFF   = 4'b0001;
  localparam logic [3:0] SSEL_SIZE1 = 4'b0010;
  localparam logic [3:0] SSEL_SIZE2 = 4'b0100;
  localparam logic [3:0] SSEL_SIZE3 = 4'b1000;

  localparam int DEF_H_MIN = 165;
  localparam int DEF_H_MAX = 780;
  localparam int DEF_V_MIN = 46;
  localparam int DEF_V_MAX = 525;

  localparam int RESET_HPOS = 320;
  localparam int RESET_VPOS = 240;

  // Upper bound is applied first so the lower bound wins if the range is empty.
  function automatic logic [CW-1:0] clamp14(input logic [CW-1:0] v,
                                            input logic [CW-1:0] lo,
                                            input logic [CW-1:0] hi);
    logic [CW-1:0] t;
    t = (v > hi) ? hi : v;
    return (t < lo) ? lo : t;
  endfunction

endpackage

// File: rtl/cursor_window_accel.sv
// Move-tick generator and step accelerator (module cursor_accel): counts frames,
// raises tick every FRAME_DIV frames and doubles the step after ACCEL_HOLD held ticks.
module cursor_accel #(
  parameter int FRAME_DIV  = 4,
  parameter int ACCEL_HOLD = 8,
  parameter int MAX_STEP   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] row_i,
  input  logic [12:0] col_i,
  input  logic [3:0]  move_i,
  output logic        tick_o,
  output logic [13:0] step_o
);

  localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int HCW = $clog2(ACCEL_HOLD + 1);
  localparam int SW  = $clog2(MAX_STEP) + 1;

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [SW-1:0]  step_q, step_d;
  logic           frame_start;
  logic           any_dir;

  assign frame_start = (row_i == 13'd0) && (col_i == 13'd0);
  assign any_dir     = (move_i != 4'b1111);
  assign tick_o      = frame_start && (fcnt_q == '0);
  assign step_o      = 14'(step_q);

  always_comb begin
    fcnt_d = fcnt_q;
    hold_d = hold_q;
    step_d = step_q;
    if (frame_start) begin
      fcnt_d = (fcnt_q == FCW'(FRAME_DIV - 1)) ? '0 : fcnt_q + 1'b1;
    end
    if (tick_o) begin
      if (any_dir) begin
        if (hold_q + 1'b1 >= HCW'(ACCEL_HOLD)) begin
          hold_d = '0;
          // MAX_STEP is a power of two, so one doubling can never overshoot it.
          if (step_q < SW'(MAX_STEP)) begin
            step_d = step_q << 1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end else begin
        hold_d = '0;
        step_d = SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      hold_q <= '0;
      step_q <= SW'(1);
    end else begin
      fcnt_q <= fcnt_d;
      hold_q <= hold_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/cursor_window.sv
// Movable square overlay window: tracks the window corner, clamps it to the
// legal area every cycle and composites border/interior/outside pixels.
module cursor_window
  import cursor_window_pkg::*;
#(
  parameter int          H_MIN        = DEF_H_MIN,
  parameter int          H_MAX        = DEF_H_MAX,
  parameter int          V_MIN        = DEF_V_MIN,
  parameter int          V_MAX        = DEF_V_MAX,
  parameter int          FRAME_DIV    = 4,
  parameter int          ACCEL_HOLD   = 8,
  parameter int          MAX_STEP     = 8,
  parameter int          BORDER_W     = 1,
  parameter logic [23:0] BORDER_COLOR = 24'h3FFFFF,
  parameter int          SIZE1        = 240,
  parameter int          SIZE2        = 120,
  parameter int          SIZE3        = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [3:0]  move,
  input  logic [3:0]  size_sel,
  input  logic [2:0]  mode_sel,
  input  logic [23:0] pixel_in,
  input  logic [23:0] pass_in,
  output logic [23:0] pixel_out,
  output logic [12:0] hpos,
  output logic [12:0] vpos
);

  localparam logic [CW-1:0] HMIN14 = CW'(H_MIN);
  localparam logic [CW-1:0] HMAX14 = CW'(H_MAX);
  localparam logic [CW-1:0] VMIN14 = CW'(V_MIN);
  localparam logic [CW-1:0] VMAX14 = CW'(V_MAX);
  localparam logic [CW-1:0] BW14   = CW'(BORDER_W);

  logic [CW-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [CW-1:0] size_q, size_d;
  mode_e         mode_q, mode_d;
  logic [23:0]   pix_q, pix_d;

  logic          tick;
  logic [CW-1:0] step;
  logic          up, dn, lf, rt;
  logic [CW-1:0] h_mv, v_mv, h_hi, v_hi;
  logic [CW-1:0] row14, col14;
  logic          in_box, inner;

  cursor_accel #(
    .FRAME_DIV (FRAME_DIV),
    .ACCEL_HOLD(ACCEL_HOLD),
    .MAX_STEP  (MAX_STEP)
  ) u_accel (
    .clk   (clk),
    .rst   (rst),
    .row_i (row),
    .col_i (col),
    .move_i(move),
    .tick_o(tick),
    .step_o(step)
  );

  assign up    = ~move[3];
  assign dn    = ~move[2];
  assign lf    = ~move[1];
  assign rt    = ~move[0];
  assign row14 = {1'b0, row};
  assign col14 = {1'b0, col};

  // Bounds use the registered size, so a new size re-clamps one cycle after it lands.
  assign h_hi = (HMAX14 > size_q) ? HMAX14 - size_q : '0;
  assign v_hi = (VMAX14 > size_q) ? VMAX14 - size_q : '0;

  always_comb begin
    h_mv = hpos_q;
    v_mv = vpos_q;
    if (tick && rt && !lf) begin
      h_mv = hpos_q + step;
    end else if (tick && lf && !rt) begin
      h_mv = (hpos_q < step) ? '0 : hpos_q - step;
    end
    if (tick && dn && !up) begin
      v_mv = vpos_q + step;
    end else if (tick && up && !dn) begin
      v_mv = (vpos_q < step) ? '0 : vpos_q - step;
    end
    hpos_d = clamp14(h_mv, HMIN14, h_hi);
    vpos_d = clamp14(v_mv, VMIN14, v_hi);
  end

  always_comb begin
    size_d = size_q;
    case (size_sel)
      SSEL_OFF:   size_d = '0;
      SSEL_SIZE1: size_d = CW'(SIZE1);
      SSEL_SIZE2: size_d = CW'(SIZE2);
      SSEL_SIZE3: size_d = CW'(SIZE3);
      default:    size_d = size_q;
    endcase
    mode_d = mode_q;
    case (mode_sel)
      MSEL_PASS_IN:  mode_d = MODE_PASS_IN;
      MSEL_PASS_OUT: mode_d = MODE_PASS_OUT;
      MSEL_INVERT:   mode_d = MODE_INVERT;
      default:       mode_d = mode_q;
    endcase
  end

  // Interior test is written without subtraction so tiny sizes cannot underflow.
  assign in_box = (col14 >= hpos_q) && (col14 < hpos_q + size_q) &&
                  (row14 >= vpos_q) && (row14 < vpos_q + size_q);
  assign inner  = (col14 >= hpos_q + BW14) && (col14 + BW14 < hpos_q + size_q) &&
                  (row14 >= vpos_q + BW14) && (row14 + BW14 < vpos_q + size_q);

  always_comb begin
    pix_d = pixel_in;
    if (size_q == '0) begin
      pix_d = pixel_in;
    end else if (in_box && !inner) begin
      pix_d = BORDER_COLOR;
    end else begin
      case (mode_q)
        MODE_PASS_IN:  pix_d = inner ? pass_in : pixel_in;
        MODE_PASS_OUT: pix_d = inner ? pixel_in : pass_in;
        MODE_INVERT:   pix_d = inner ? ~pixel_in : pixel_in;
        default:       pix_d = pixel_in;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q <= CW'(RESET_HPOS);
      vpos_q <= CW'(RESET_VPOS);
      size_q <= '0;
      mode_q <= MODE_PASS_IN;
      pix_q  <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      size_q <= size_d;
      mode_q <= mode_d;
      pix_q  <= pix_d;
    end
  end

  assign pixel_out = pix_q;
  assign hpos      = hpos_q[12:0];
  assign vpos      = vpos_q[12:0];

endmodule

// File: tb/tb_cursor_window.sv
// Self-checking bench for cursor_window: directed scenarios plus random traffic
// compared every cycle against a behavioural window model.
module tb_cursor_window;

  localparam int          H_MIN = 165, H_MAX = 780, V_MIN = 46, V_MAX = 525;
  localparam int          FRAME_DIV = 4, ACCEL_HOLD = 8, MAX_STEP = 8, BW = 2;
  localparam logic [23:0] BORDER = 24'h3FFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] row = 13'd5, col = 13'd5;
  logic [3:0]  move = 4'b1111, size_sel = 4'b0000;
  logic [2:0]  mode_sel = 3'b000;
  logic [23:0] pixel_in = '0, pass_in = '0;
  logic [23:0] pixel_out;
  logic [12:0] hpos, vpos;

  always #5 clk = ~clk;

  cursor_window #(.BORDER_W(BW)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .move(move),
    .size_sel(size_sel), .mode_sel(mode_sel), .pixel_in(pixel_in),
    .pass_in(pass_in), .pixel_out(pixel_out), .hpos(hpos), .vpos(vpos)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: window corner, size, mode (0 in, 1 out, 2 invert), accel state.
  int m_h, m_v, m_sz, m_md, m_step, m_hold, m_fc;
  logic [23:0] last_pix, last_pas;

  task automatic model_reset();
    m_h = 320; m_v = 240; m_sz = 0; m_md = 0; m_step = 1; m_hold = 0; m_fc = 0;
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    int t;
    t = (x > hi) ? hi : x;
    return (t < lo) ? lo : t;
  endfunction

  function automatic logic [23:0] ref_pix(input int r, input int c,
                                          input logic [23:0] p, input logic [23:0] q);
    bit inb, inr;
    if (m_sz == 0) return p;
    inb = (c >= m_h) && (c < m_h + m_sz) && (r >= m_v) && (r < m_v + m_sz);
    inr = (c >= m_h + BW) && (c < m_h + m_sz - BW) && (r >= m_v + BW) && (r < m_v + m_sz - BW);
    if (inb && !inr) return BORDER;
    if (m_md == 1) return inr ? p : q;
    if (m_md == 2) return inr ? ~p : p;
    return inr ? q : p;
  endfunction

  task automatic model_step(input int r, input int c, input logic [3:0] mv,
                            input logic [3:0] sz, input logic [2:0] md);
    bit fs, tk;
    int nh, nv, dx, dy;
    fs = (r == 0) && (c == 0);
    tk = fs && (m_fc == 0);
    if (fs) m_fc = (m_fc + 1) % FRAME_DIV;
    nh = m_h; nv = m_v;
    if (tk) begin
      dx = (mv[0] ? 0 : 1) - (mv[1] ? 0 : 1);
      dy = (mv[2] ? 0 : 1) - (mv[3] ? 0 : 1);
      nh = m_h + dx * m_step;
      nv = m_v + dy * m_step;
      if (mv != 4'b1111) begin
        m_hold++;
        if (m_hold == ACCEL_HOLD) begin
          m_hold = 0;
          m_step = (m_step * 2 > MAX_STEP) ? MAX_STEP : m_step * 2;
        end
      end else begin
        m_hold = 0; m_step = 1;
      end
    end
    m_h = clampi(nh, H_MIN, H_MAX - m_sz);
    m_v = clampi(nv, V_MIN, V_MAX - m_sz);
    case (sz)
      4'b0001: m_sz = 0;
      4'b0010: m_sz = 240;
      4'b0100: m_sz = 120;
      4'b1000: m_sz = 60;
      default: ;
    endcase
    case (md)
      3'b001:  m_md = 0;
      3'b010:  m_md = 1;
      3'b100:  m_md = 2;
      default: ;
    endcase
  endtask

  task automatic cyc(input logic [12:0] r, input logic [12:0] c, input logic [3:0] mv,
                     input logic [3:0] sz, input logic [2:0] md);
    logic [23:0] ep;
    row = r; col = c; move = mv; size_sel = sz; mode_sel = md;
    pixel_in = 24'($urandom); pass_in = 24'($urandom);
    last_pix = pixel_in; last_pas = pass_in;
    ep = ref_pix(int'(r), int'(c), pixel_in, pass_in);
    model_step(int'(r), int'(c), mv, sz, md);
    @(posedge clk); #1;
    chk("pixel_out", {8'h0, pixel_out}, {8'h0, ep});
    chk("hpos", {19'h0, hpos}, m_h);
    chk("vpos", {19'h0, vpos}, m_v);
  endtask

  // Non-frame-start coordinate, biased toward the window so borders get exercised.
  task automatic rand_rc(output logic [12:0] r, output logic [12:0] c);
    if (m_sz > 0 && $urandom_range(0, 3) != 0) begin
      r = 13'(m_v - 3 + int'($urandom % 32'(m_sz + 6)));
      c = 13'(m_h - 3 + int'($urandom % 32'(m_sz + 6)));
    end else begin
      r = 13'(1 + $urandom % 600);
      c = 13'($urandom % 800);
    end
  endtask

  task automatic frame(input logic [3:0] mv);
    logic [12:0] r, c;
    cyc(13'd0, 13'd0, mv, 4'b0000, 3'b000);
    repeat (3) begin
      rand_rc(r, c);
      cyc(r, c, mv, 4'b0000, 3'b000);
    end
  endtask

  task automatic ticks(input logic [3:0] mv, input int n);
    repeat (n * FRAME_DIV) frame(mv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_hpos", {19'h0, hpos}, 32'd320);
    chk("rst_vpos", {19'h0, vpos}, 32'd240);
    chk("rst_pixel_out", {8'h0, pixel_out}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [12:0] r, c;
    logic [3:0]  cur_mv, sz;
    logic [2:0]  md;
    model_reset();
    #2;
    do_reset();

    // Idle frames: position holds and pixels pass straight through one cycle late.
    repeat (8) begin
      frame(4'b1111);
      chk("delay", {8'h0, pixel_out}, {8'h0, last_pix});
    end
    chk("idle_hpos", {19'h0, hpos}, 32'd320);
    chk("idle_vpos", {19'h0, vpos}, 32'd240);

    // Acceleration: 8 ticks at step 1 then 4 at step 2.
    cyc(13'd5, 13'd5, 4'b1111, 4'b0100, 3'b000);
    ticks(4'b1110, 12);
    chk("accel_hpos", {19'h0, hpos}, 32'd336);
    ticks(4'b1111, 1);
    ticks(4'b1110, 1);
    chk("step_reset", {19'h0, hpos}, 32'd337);

    // Saturation at the right bound, then a smaller size frees movement.
    cyc(13'd5, 13'd5, 4'b1111, 4'b0010, 3'b000);
    ticks(4'b1110, 50);
    chk("sat240", {19'h0, hpos}, 32'd540);
    cyc(13'd5, 13'd5, 4'b1110, 4'b1000, 3'b000);
    cyc(13'd5, 13'd5, 4'b1110, 4'b0000, 3'b000);
    chk("hold540", {19'h0, hpos}, 32'd540);
    ticks(4'b1110, 1);
    chk("resume", {31'h0, (hpos > 13'd540)}, 32'd1);
    ticks(4'b1110, 25);
    chk("sat60", {19'h0, hpos}, 32'd720);
    ticks(4'b1111, 1);
    ticks(4'b1101, 14);
    chk("at700", {19'h0, hpos}, 32'd700);
    cyc(13'd5, 13'd5, 4'b1111, 4'b0010, 3'b000);
    cyc(13'd5, 13'd5, 4'b1111, 4'b0000, 3'b000);
    chk("reclamp", {19'h0, hpos}, 32'd540);

    // Border and interior compositing, size 60 at (320,240).
    do_reset();
    cyc(13'd5, 13'd5, 4'b1111, 4'b1000, 3'b000);
    cyc(13'd250, 13'd321, 4'b1111, 4'b0000, 3'b000);
    chk("border321", {8'h0, pixel_out}, {8'h0, BORDER});
    cyc(13'd250, 13'd322, 4'b1111, 4'b0000, 3'b000);
    chk("passin322", {8'h0, pixel_out}, {8'h0, last_pas});
    cyc(13'd5, 13'd5, 4'b1111, 4'b0000, 3'b100);
    cyc(13'd250, 13'd322, 4'b1111, 4'b0000, 3'b000);
    chk("invert322", {8'h0, pixel_out}, {8'h0, ~last_pix});
    cyc(13'd5, 13'd5, 4'b1111, 4'b0000, 3'b010);
    cyc(13'd250, 13'd322, 4'b1111, 4'b0000, 3'b000);
    chk("passout_in", {8'h0, pixel_out}, {8'h0, last_pix});
    cyc(13'd250, 13'd500, 4'b1111, 4'b0000, 3'b000);
    chk("passout_out", {8'h0, pixel_out}, {8'h0, last_pas});

    // Opposing directions cancel; reset mid-frame discards everything.
    ticks(4'b0011, 4);
    chk("updown_vpos", {19'h0, vpos}, 32'd240);
    frame(4'b1110);
    frame(4'b1110);
    cyc(13'd100, 13'd200, 4'b1110, 4'b0000, 3'b000);
    do_reset();
    frame(4'b1110);
    chk("first_tick", {19'h0, hpos}, 32'd321);

    // Random traffic against the model.
    cur_mv = 4'b1111;
    repeat (4000) begin
      if ($urandom_range(0, 199) == 0) cur_mv = 4'($urandom);
      sz = ($urandom_range(0, 299) == 0) ? 4'($urandom) : 4'b0000;
      md = ($urandom_range(0, 99) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 7) == 0) begin
        r = 13'd0; c = 13'd0;
      end else begin
        rand_rc(r, c);
      end
      cyc(r, c, cur_mv, sz, md);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cursor_window.md
CURSOR_WINDOW -- requirements
Module: cursor_window

Interface
REQ-001 Parameter H_MIN, default 165, meaning leftmost legal window column.
REQ-002 Parameter H_MAX, default 780, meaning column bound; window right edge stays below it.
REQ-003 Parameter V_MIN, default 46, meaning topmost legal window row.
REQ-004 Parameter V_MAX, default 525, meaning row bound; window bottom edge stays below it.
REQ-005 Parameter FRAME_DIV, default 4, meaning frames per move tick, power of two, at least 1.
REQ-006 Parameter ACCEL_HOLD, default 8, meaning consecutive held ticks before the step doubles.
REQ-007 Parameter MAX_STEP, default 8, meaning step ceiling in pixels, power of two.
REQ-008 Parameter BORDER_W, default 1, meaning border thickness in pixels, range 1..4.
REQ-009 Parameter BORDER_COLOR, default 24'h3FFFFF, meaning border pixel value.
REQ-010 Parameter SIZE1/SIZE2/SIZE3, defaults 240/120/60, meaning square window sizes.
REQ-011 clk  in  1  sole clock, rising edge.
REQ-012 rst  in  1  asynchronous active-high reset.
REQ-013 row, col  in  13 each  current raster coordinate.
REQ-014 move  in  4  active-low {up, down, left, right}.
REQ-015 size_sel  in  4  one-hot {SIZE3, SIZE2, SIZE1, off}; other codes hold the current size.
REQ-016 mode_sel  in  3  one-hot {invert, pass-outside, pass-inside}; other codes hold the current mode.
REQ-017 pixel_in, pass_in  in  24 each  live pixel and alternate-source pixel.
REQ-018 pixel_out  out  24  composited pixel.
REQ-019 hpos, vpos  out  13 each  current window top-left corner.

Function
REQ-020 Frame start SHALL be the cycle with row==0 and col==0; the frame counter SHALL increment modulo FRAME_DIV there.
REQ-021 A move tick SHALL be a frame start with the frame counter equal to 0.
REQ-022 At a tick, each active direction SHALL move its axis by the current step.
REQ-023 Up+down both active SHALL leave vpos unchanged; left+right both active SHALL leave hpos unchanged.
REQ-024 A tick with any direction active SHALL increment hold_cnt, saturating at ACCEL_HOLD.
REQ-025 When hold_cnt reaches ACCEL_HOLD, step SHALL double up to MAX_STEP and hold_cnt SHALL clear.
REQ-026 A tick with no direction active SHALL set step=1 and hold_cnt=0.
REQ-027 Every cycle, hpos SHALL be clamped to [H_MIN, H_MAX-size] and vpos to [V_MIN, V_MAX-size]; a move overshooting a bound SHALL land on the bound exactly.
REQ-028 A size change SHALL take effect on the next cycle, and re-clamping SHALL complete within one further cycle.
REQ-029 Arithmetic SHALL be 14-bit unsigned internally so that no sum or difference wraps.
REQ-030 Border region: pixels with hpos<=col<hpos+size and vpos<=row<vpos+size, minus the interior.
REQ-031 Interior: the box inset by BORDER_W on each side.
REQ-032 Compositing: size==0 selects pixel_in.
REQ-033 Compositing: border selects BORDER_COLOR.
REQ-034 Pass-inside mode: interior=pass_in, outside=pixel_in.
REQ-035 Pass-outside mode: interior=pixel_in, outside=pass_in.
REQ-036 Invert mode: interior=~pixel_in, outside=pixel_in.
REQ-037 pixel_out SHALL be registered, with latency exactly 1 cycle from pixel_in/row/col.

Reset
REQ-038 rst SHALL asynchronously set hpos=320, vpos=240, size=0, mode=pass-inside, step=1, hold_cnt=0, frame counter=0, pixel_out=0.
REQ-039 Reset asserted mid-frame or mid-acceleration SHALL discard all accumulated state; the first tick after release occurs at the first frame start.

Structure
REQ-040 A shared package SHALL hold the mode encoding constants, the size-select codes, and the default bounds.
REQ-041 One sub-module, cursor_accel, SHALL own the frame counter, hold_cnt and step, and output tick and step.

Verification
REQ-042 Reset release, move=4'b1111, 8 frames -> hpos=320, vpos=240, pixel_out==pixel_in delayed 1 cycle.
REQ-043 size_sel=0100 (120), right held 12 ticks -> hpos steps 1×8, then 2×4, giving hpos=336; release then 1 tick -> step back to 1.
REQ-044 size 240, hpos=535, right held -> hpos saturates at 540; switch to size 60 -> hpos still 540 and movement resumes.
REQ-045 At hpos=700 with size 60, select size 240 -> hpos=540 within 2 cycles.
REQ-046 size 60, BORDER_W=2, hpos=320: column 321 -> BORDER_COLOR; column 322 in pass-inside -> pass_in; in invert -> ~pixel_in.
REQ-047 up+down held 4 ticks -> vpos unchanged; assert rst mid-frame -> all state at reset values immediately.
